// File: rtl/rf_debug_port.sv
// Debug/bring-up engine for the 32 x XLEN register file.
// Dump mode streams x0..x31 out over valid/ready; load mode writes x1..x31
// from an incoming valid/ready stream. The register-file side signals are
// combinational so the top level can mux them straight onto the RF ports.
module rf_debug_port #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREG)-1:0]   rf_rs,
  input  logic [XLEN-1:0]           rf_rdata,
  output logic                      rf_we,
  output logic [$clog2(NREG)-1:0]   rf_rd,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_data,
  output logic [$clog2(NREG)-1:0]   out_idx,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_data
);

  localparam int unsigned IW = $clog2(NREG);
  // One extra counter bit so the post-last value NREG is representable.
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] IDX_END  = CW'(NREG);
  localparam logic [CW-1:0] IDX_LAST = CW'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] idx;
  logic          free;

  // Dump output register may take a new word when empty or being drained.
  assign free = !out_valid || out_ready;

  // Register-file and load-stream side: combinational so writes land in the same cycle.
  assign in_ready = (state == S_LOAD);
  assign rf_we    = in_ready && in_valid;
  assign rf_rd    = in_ready ? idx[IW-1:0] : '0;
  assign rf_wdata = in_ready ? in_data : '0;
  assign rf_rs    = (state == S_DUMP) ? idx[IW-1:0] : '0;

  // Sequencer: state, register counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (mode) begin
              idx   <= CW'(1);
              state <= S_LOAD;
            end else begin
              idx   <= '0;
              state <= S_DUMP;
            end
          end
        end
        S_DUMP: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (free) begin
            if (idx < IDX_END) begin
              out_data  <= rf_rdata;
              out_idx   <= idx[IW-1:0];
              out_valid <= 1'b1;
              idx       <= idx + CW'(1);
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          // A word offered alongside abort is still written combinationally.
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (in_valid) begin
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_debug_port.sv
// Directed/randomized bench for rf_debug_port with a behavioural RF model.
module tb_rf_debug_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [4:0]  rf_rs, rf_rd, out_idx;
  logic [63:0] rf_rdata, rf_wdata, out_data;
  logic        rf_we, out_valid, in_ready;
  logic        out_ready = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;

  rf_debug_port #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done),
    .rf_rs(rf_rs), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clk = ~clk;

  // Register file the DUT talks to, with a bench-side preload port.
  logic [63:0] regs [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [63:0] pl_data = 64'd0;
  int          x0_writes = 0;

  assign rf_rdata = regs[rf_rs];

  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_data;
    else if (rf_we) regs[rf_rd] <= rf_wdata;
    if (rf_we && rf_rd == 5'd0) x0_writes <= x0_writes + 1;
  end

  // Expected architectural contents of the register file.
  logic [63:0] model [32];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic compare_regs(input string tag);
    for (int k = 0; k < 32; k++) chk($sformatf("%s_x%0d", tag, k), regs[k], model[k]);
  endtask

  // rmode: 0 ready high, 1 pattern 1-0-0-1, 2 random. abort_at < 0 means no abort.
  task automatic run_dump(input int rmode, input int abort_at, input bit poke_start);
    logic [63:0] exp_d [32];
    int          beats;
    bit          stall, finished, last_prev, r;
    logic [63:0] hd;
    logic [4:0]  hi;
    beats = 0; stall = 0; finished = 0; last_prev = 0; hd = '0; hi = '0;
    for (int k = 0; k < 32; k++) exp_d[k] = model[k];
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("dump_busy", busy, 1);
    chk("dump_lat0_valid", out_valid, 0);
    for (int c = 0; c < 400 && !finished; c++) begin
      if (c == 1) chk("dump_first_valid", out_valid, 1);
      if (stall) begin
        chk("dump_hold_data", out_data, hd);
        chk("dump_hold_idx", out_idx, hi);
      end
      if (last_prev) begin
        chk("dump_done_pulse", done, 1);
        chk("dump_done_busy", busy, 1);
        finished = 1;
      end else begin
        chk("dump_no_early_done", done, 0);
        if (abort_at >= 0 && beats == abort_at && out_valid) begin
          abort = 1'b1; out_ready = 1'b0;
          tick();
          abort = 1'b0;
          chk("abort_valid_drop", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_no_done", done, 0);
          tick();
          chk("abort_no_done2", done, 0);
          return;
        end
        case (rmode)
          0: r = 1'b1;
          1: r = (c % 4 == 0) || (c % 4 == 3);
          default: r = 1'($urandom % 2);
        endcase
        out_ready = r;
        if (poke_start && c == 5) begin start = 1'b1; mode = 1'b1; end
        stall = out_valid && !r;
        if (stall) begin hd = out_data; hi = out_idx; end
        if (out_valid && r) begin
          chk("dump_idx", 64'(out_idx), 64'(beats));
          chk("dump_data", out_data, exp_d[beats]);
          beats++;
          if (beats == 32) last_prev = 1;
        end
        tick();
        start = 1'b0; mode = 1'b0;
      end
    end
    if (!finished) chk("dump_timeout", 0, 1);
    chk("dump_beats", 64'(beats), 32);
    out_ready = 1'b1;
    tick();
    chk("dump_idle_busy", busy, 0);
    chk("dump_idle_done", done, 0);
    chk("dump_idle_valid", out_valid, 0);
  endtask

  // gmode: 0 no gaps, 1 gaps, 2 gaps + random data. rst_after >= 0 resets after that many writes.
  task automatic run_load(input int gmode, input int rst_after, input logic [63:0] base);
    int          seq;
    bit          v;
    logic [63:0] d;
    seq = 0;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    chk("load_busy", busy, 1);
    for (int c = 0; c < 400 && seq < 31; c++) begin
      if (rst_after >= 0 && seq == rst_after) begin
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rd", 64'(rf_rd), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_after_busy", busy, 0);
        chk("rst_after_done", done, 0);
        return;
      end
      v = (gmode == 0) ? 1'b1 : ($urandom % 3 != 0);
      d = (gmode == 2) ? {$urandom, $urandom} : base + 64'(seq);
      in_valid = v; in_data = d;
      #1;
      chk("load_in_ready", in_ready, 1);
      chk("load_we", rf_we, v);
      chk("load_no_done", done, 0);
      if (v) begin
        chk("load_rd", 64'(rf_rd), 64'(seq + 1));
        chk("load_wdata", rf_wdata, d);
        model[seq + 1] = d;
        seq++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("load_count", 64'(seq), 31);
    chk("load_done_pulse", done, 1);
    chk("load_done_busy", busy, 1);
    chk("load_done_we", rf_we, 0);
    tick();
    chk("load_idle_busy", busy, 0);
    chk("load_idle_done", done, 0);
  endtask

  initial begin
    // Preload while the DUT is held in reset.
    for (int k = 0; k < 32; k++) begin
      model[k] = (k == 0) ? 64'd0 : 64'h1000 + 64'(k);
      pl_en = 1'b1; pl_addr = 5'(k); pl_data = model[k];
      tick();
    end
    pl_en = 1'b0;
    chk("rst_state_busy", busy, 0);
    chk("rst_state_done", done, 0);
    chk("rst_state_valid", out_valid, 0);
    chk("rst_state_data", out_data, 0);
    chk("rst_state_idx", 64'(out_idx), 0);
    chk("rst_state_we", rf_we, 0);
    chk("rst_state_rs", 64'(rf_rs), 0);
    chk("rst_state_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run_dump(0, -1, 1'b0);
    run_dump(1, -1, 1'b0);
    run_load(0, -1, 64'hA0);
    compare_regs("load_full");
    run_load(1, -1, 64'hA0);
    compare_regs("load_gaps");
    run_load(2, -1, 64'h0);
    compare_regs("load_rand");
    run_dump(2, -1, 1'b1);
    run_dump(0, 10, 1'b0);
    run_dump(0, -1, 1'b0);
    run_load(0, 5, 64'hC0);
    compare_regs("load_rst");
    run_dump(2, -1, 1'b0);

    chk("x0_never_written", 64'(x0_writes), 0);
    chk("x0_zero", regs[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
